// File: rtl/elelock_ctrl_pkg.sv
// Purpose: shared types and helpers for the keypad lock controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package elelock_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_OPEN    = 3'd2,
      ST_LOCKOUT = 3'd3,
      ST_PROGRAM = 3'd4
   } state_t;

   localparam int              DIGIT_W       = 4;
   localparam int              NUM_KEYS      = 10;
   localparam logic [DIGIT_W-1:0] DIGIT_INVALID = 4'hF;

   // Index of the single set bit; anything other than exactly one bit -> 4'hF.
   function automatic logic [DIGIT_W-1:0] onehot_to_digit(input logic [NUM_KEYS-1:0] keys);
      logic [DIGIT_W-1:0] d;
      int                 n;
      d = DIGIT_INVALID;
      n = 0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (keys[k]) begin
            n = n + 1;
            d = DIGIT_W'(k);
         end
      end
      if (n != 1) begin
         d = DIGIT_INVALID;
      end
      return d;
   endfunction

endpackage

// File: rtl/elelock_ctrl_if.sv
// Purpose: keypad/door/status bundle between the lock controller and its environment.
// Ports: tenkey/close/setmode toward the controller; lock/alarm/digit_cnt/code_updated back.
// Backpressure: none, all signals are plain levels or single-cycle pulses.
interface elelock_ctrl_if;

   logic [9:0] tenkey;
   logic       close;
   logic       setmode;
   logic       lock;
   logic       alarm;
   logic [2:0] digit_cnt;
   logic       code_updated;

   // Environment (keypad/door side) drives requests and observes status.
   modport master (
      output tenkey, close, setmode,
      input  lock, alarm, digit_cnt, code_updated
   );

   // Controller side.
   modport slave (
      input  tenkey, close, setmode,
      output lock, alarm, digit_cnt, code_updated
   );

endinterface

// File: rtl/elelock_ctrl_keyscan.sv
// Purpose: turns raw one-hot keypad levels into one event per press (press edge only).
// Latency: key_valid_o is combinational in the cycle the press is first seen.
// Backpressure: none; ports clk/reset, tenkey_i in, key_valid_o/key_digit_o out.
module elelock_keyscan
   import elelock_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] tenkey_i,
   output logic                key_valid_o,
   output logic [DIGIT_W-1:0]  key_digit_o
);

   logic [NUM_KEYS-1:0] tenkey_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tenkey_q <= '0;
      end else begin
         tenkey_q <= tenkey_i;
      end
   end

   assign key_digit_o = onehot_to_digit(tenkey_i);
   // A press counts only when the keypad was fully released the cycle before,
   // so held keys and transitions between patterns never re-trigger.
   assign key_valid_o = (tenkey_q == '0) && (key_digit_o != DIGIT_INVALID);

endmodule

// File: rtl/elelock_ctrl.sv
// Purpose: keypad lock sequencer: code entry, compare, auto-relock, fail lockout, code change.
// Latency: lock opens 2 edges after the final digit is first seen; outputs are registered.
// Backpressure: none; ports clk/reset plus the slave side of elelock_ctrl_if.
module elelock_ctrl
   import elelock_ctrl_pkg::*;
#(
   parameter int                          DIGITS      = 4,
   parameter logic [DIGITS*DIGIT_W-1:0]   INIT_CODE   = 16'h7301,
   parameter int                          RELOCK_CYC  = 1000,
   parameter int                          LOCKOUT_CYC = 5000,
   parameter int                          MAX_FAIL    = 3
)
(
   input  logic          clk,
   input  logic          reset,
   elelock_ctrl_if.slave bus
);

   localparam int CODE_W  = DIGITS * DIGIT_W;
   localparam int TMAX    = (RELOCK_CYC > LOCKOUT_CYC) ? RELOCK_CYC : LOCKOUT_CYC;
   localparam int TIMER_W = $clog2(TMAX + 1);
   localparam int FAIL_W  = $clog2(MAX_FAIL + 1);

   logic               key_valid;
   logic [DIGIT_W-1:0] key_digit;

   elelock_keyscan u_keyscan (
      .clk         (clk),
      .reset       (reset),
      .tenkey_i    (bus.tenkey),
      .key_valid_o (key_valid),
      .key_digit_o (key_digit)
   );

   state_t              state_q, state_d;
   logic [CODE_W-1:0]   entry_q, entry_d;
   logic [CODE_W-1:0]   code_q,  code_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [FAIL_W-1:0]   fail_q,  fail_d;
   logic [2:0]          cnt_q,   cnt_d;
   logic                lock_q,  lock_d;
   logic                alarm_q, alarm_d;
   logic                upd_q,   upd_d;

   logic [CODE_W-1:0]   entry_with_key;
   logic                last_digit;
   logic                timer_expiring;

   always_comb begin
      entry_with_key = entry_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (cnt_q == 3'(i)) begin
            entry_with_key[i*DIGIT_W +: DIGIT_W] = key_digit;
         end
      end
   end

   assign last_digit     = (cnt_q == 3'(DIGITS - 1));
   // Timer counts the cycles spent in the state; leaving on the cycle it would
   // hit zero gives exactly RELOCK_CYC / LOCKOUT_CYC cycles of residence.
   assign timer_expiring = (timer_q <= TIMER_W'(1));

   always_comb begin
      state_d = state_q;
      entry_d = entry_q;
      code_d  = code_q;
      timer_d = timer_q;
      fail_d  = fail_q;
      cnt_d   = cnt_q;
      lock_d  = lock_q;
      alarm_d = alarm_q;
      upd_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.close) begin
               cnt_d = '0;                 // close wins, a coincident key is dropped
            end else if (key_valid) begin
               entry_d = entry_with_key;
               cnt_d   = cnt_q + 3'd1;
               if (last_digit) begin
                  state_d = ST_CHECK;
               end
            end
         end

         ST_CHECK: begin
            cnt_d = '0;
            if (entry_q == code_q) begin
               state_d = ST_OPEN;
               fail_d  = '0;
               timer_d = TIMER_W'(RELOCK_CYC);
               lock_d  = 1'b0;
            end else if (int'(fail_q) + 1 >= MAX_FAIL) begin
               state_d = ST_LOCKOUT;
               fail_d  = FAIL_W'(MAX_FAIL);  // saturate
               alarm_d = 1'b1;
               timer_d = TIMER_W'(LOCKOUT_CYC);
            end else begin
               state_d = ST_IDLE;
               fail_d  = fail_q + FAIL_W'(1);
            end
         end

         ST_OPEN: begin
            if (bus.close || timer_expiring) begin
               state_d = ST_IDLE;
               lock_d  = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
               if (bus.setmode) begin
                  state_d = ST_PROGRAM;
                  cnt_d   = '0;
               end
            end
         end

         ST_PROGRAM: begin
            if (bus.close) begin
               state_d = ST_IDLE;
               lock_d  = 1'b1;
               cnt_d   = '0;
            end else if (key_valid) begin
               entry_d = entry_with_key;
               if (last_digit) begin
                  code_d  = entry_with_key;
                  upd_d   = 1'b1;
                  state_d = ST_OPEN;
                  timer_d = TIMER_W'(RELOCK_CYC);
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end

         ST_LOCKOUT: begin
            if (timer_expiring) begin
               state_d = ST_IDLE;
               alarm_d = 1'b0;
               fail_d  = '0;
               cnt_d   = '0;
               timer_d = '0;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            lock_d  = 1'b1;
            alarm_d = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         entry_q <= '0;
         code_q  <= INIT_CODE;
         timer_q <= '0;
         fail_q  <= '0;
         cnt_q   <= '0;
         lock_q  <= 1'b1;
         alarm_q <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         entry_q <= entry_d;
         code_q  <= code_d;
         timer_q <= timer_d;
         fail_q  <= fail_d;
         cnt_q   <= cnt_d;
         lock_q  <= lock_d;
         alarm_q <= alarm_d;
         upd_q   <= upd_d;
      end
   end

   // cnt_q is cleared on every path into OPEN/LOCKOUT, so it reads 0 there.
   assign bus.lock         = lock_q;
   assign bus.alarm        = alarm_q;
   assign bus.digit_cnt    = cnt_q;
   assign bus.code_updated = upd_q;

endmodule

// File: tb/tb_elelock_ctrl.sv
// Purpose: self-checking bench for elelock_ctrl with a code-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_elelock_ctrl;

   typedef int code_t[4];

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   elelock_ctrl_if bus ();

   elelock_ctrl #(
      .RELOCK_CYC  (8),
      .LOCKOUT_CYC (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int    tests = 0;
   int    fails = 0;
   code_t init_code = '{1, 0, 3, 7};
   code_t code_m;          // model: currently stored code
   int    fail_m;          // model: consecutive failures

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit same(input code_t a, input code_t b);
      for (int i = 0; i < 4; i++) if (a[i] != b[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic rand_other(input code_t avoid, output code_t e);
      do begin
         for (int i = 0; i < 4; i++) e[i] = $urandom_range(0, 9);
      end while (same(e, avoid));
   endtask

   // Enter a full code in IDLE; returns 0 = rejected, 1 = opened, 2 = lockout.
   task automatic enter(input code_t e, output int outcome);
      for (int i = 0; i < 4; i++) begin
         bus.tenkey = 10'(1 << e[i]);
         tick();
         bus.tenkey = '0;
         if (i < 3) begin
            check("entry_cnt", bus.digit_cnt, i + 1);
            tick();
         end
      end
      check("lock_during_check", bus.lock, 1);
      tick();
      if (same(e, code_m)) begin
         fail_m  = 0;
         outcome = 1;
         check("open_lock", bus.lock, 0);
         check("open_alarm", bus.alarm, 0);
      end else begin
         fail_m++;
         if (fail_m >= 3) begin
            outcome = 2;
            check("lockout_alarm", bus.alarm, 1);
            check("lockout_lock", bus.lock, 1);
         end else begin
            outcome = 0;
            check("reject_lock", bus.lock, 1);
            check("reject_alarm", bus.alarm, 0);
            check("reject_cnt", bus.digit_cnt, 0);
         end
      end
   endtask

   task automatic close_door();
      bus.close = 1'b1;
      tick();
      bus.close = 1'b0;
      check("close_lock", bus.lock, 1);
   endtask

   // Sits out the 16-cycle lockout, pressing keys that must be ignored.
   task automatic ride_lockout();
      for (int k = 0; k < 7; k++) begin
         bus.tenkey = 10'(1 << $urandom_range(0, 9));
         tick();
         bus.tenkey = '0;
         tick();
         check("lockout_keys_ignored", bus.digit_cnt, 0);
      end
      check("lockout_alarm_held", bus.alarm, 1);
      tick();
      check("lockout_alarm_last", bus.alarm, 1);
      tick();
      check("lockout_end_alarm", bus.alarm, 0);
      check("lockout_end_lock", bus.lock, 1);
      fail_m = 0;
   endtask

   initial begin
      int    res;
      int    pulses;
      code_t e;
      code_t nc;

      bus.tenkey  = '0;
      bus.close   = 1'b0;
      bus.setmode = 1'b0;
      reset       = 1'b1;
      code_m      = init_code;
      fail_m      = 0;
      #12;
      check("rst_lock", bus.lock, 1);
      check("rst_alarm", bus.alarm, 0);
      check("rst_cnt", bus.digit_cnt, 0);
      check("rst_upd", bus.code_updated, 0);
      reset = 1'b0;
      tick();

      // Correct code, then auto-relock after 8 cycles open.
      enter(init_code, res);
      for (int k = 0; k < 7; k++) begin
         tick();
         check("open_hold", bus.lock, 0);
      end
      tick();
      check("auto_relock", bus.lock, 1);

      // Held key then a multi-bit pattern: only one digit registers.
      bus.tenkey = 10'b0000000010;
      repeat (5) tick();
      bus.tenkey = 10'b0000001001;
      tick();
      bus.tenkey = '0;
      tick();
      check("held_cnt", bus.digit_cnt, 1);
      check("held_lock", bus.lock, 1);
      close_door();
      check("close_clears_cnt", bus.digit_cnt, 0);

      // Three wrong entries -> lockout, then the right code opens.
      for (int t = 0; t < 3; t++) begin
         rand_other(code_m, e);
         enter(e, res);
      end
      check("lockout_outcome", res, 2);
      ride_lockout();
      enter(code_m, res);
      check("post_lockout_open", res, 1);
      close_door();

      // Code change from OPEN.
      enter(code_m, res);
      bus.setmode = 1'b1;
      tick();
      bus.setmode = 1'b0;
      check("program_lock", bus.lock, 0);
      rand_other(code_m, nc);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         bus.tenkey = 10'(1 << nc[i]);
         tick();
         pulses += int'(bus.code_updated);
         if (i < 3) check("program_cnt", bus.digit_cnt, i + 1);
         else       check("upd_pulse", bus.code_updated, 1);
         bus.tenkey = '0;
         tick();
         pulses += int'(bus.code_updated);
      end
      check("upd_single", pulses, 1);
      check("after_program_open", bus.lock, 0);
      code_m = nc;
      close_door();
      enter(init_code, res);
      check("old_code_rejected", res, 0);
      enter(code_m, res);
      check("new_code_opens", res, 1);
      close_door();

      // Close coincident with the 4th digit drops it.
      for (int i = 0; i < 3; i++) begin
         bus.tenkey = 10'(1 << code_m[i]);
         tick();
         bus.tenkey = '0;
         tick();
      end
      check("pre_close_cnt", bus.digit_cnt, 3);
      bus.tenkey = 10'(1 << code_m[3]);
      bus.close  = 1'b1;
      tick();
      bus.tenkey = '0;
      bus.close  = 1'b0;
      check("simul_close_cnt", bus.digit_cnt, 0);
      tick();
      check("simul_close_lock", bus.lock, 1);

      // Abort PROGRAM after 2 digits: old code remains.
      enter(code_m, res);
      bus.setmode = 1'b1;
      tick();
      bus.setmode = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.tenkey = 10'(1 << ((code_m[i] + 1) % 10));
         tick();
         bus.tenkey = '0;
         tick();
      end
      check("abort_cnt", bus.digit_cnt, 2);
      close_door();
      enter(code_m, res);
      check("abort_keeps_code", res, 1);
      close_door();

      // Async reset mid-entry (also reverts the code).
      for (int i = 0; i < 3; i++) begin
         bus.tenkey = 10'(1 << init_code[i]);
         tick();
         bus.tenkey = '0;
         tick();
      end
      check("mid_entry_cnt", bus.digit_cnt, 3);
      #3 reset = 1'b1;
      #1;
      check("async_rst_cnt", bus.digit_cnt, 0);
      check("async_rst_lock", bus.lock, 1);
      #1 reset = 1'b0;
      code_m = init_code;
      fail_m = 0;
      tick();
      enter(init_code, res);
      check("code_reverted", res, 1);
      #3 reset = 1'b1;
      #1;
      check("async_rst_open_lock", bus.lock, 1);
      check("async_rst_open_alarm", bus.alarm, 0);
      check("async_rst_open_cnt", bus.digit_cnt, 0);
      #1 reset = 1'b0;
      tick();

      // Randomized mix of right and wrong entries against the model.
      for (int t = 0; t < 10; t++) begin
         if ($urandom_range(0, 2) == 0) e = code_m;
         else rand_other(code_m, e);
         enter(e, res);
         if (res == 1) close_door();
         else if (res == 2) ride_lockout();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
